// File: rtl/adder_arbiter.sv
// Two-requester round-robin front end sharing one ripple-carry adder, with a
// one-deep registered result stage. Define ADDER_ARB_STATS_EN for per-requester transfer counters.

module adder_rca #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] s,
    output logic             c
);
    logic [WIDTH:0] carry_s;

    assign carry_s[0] = 1'b0;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        assign s[i]         = a[i] ^ b[i] ^ carry_s[i];
        assign carry_s[i+1] = (a[i] & b[i]) | (carry_s[i] & (a[i] ^ b[i]));
    end

    assign c = carry_s[WIDTH];
endmodule

module adder_arbiter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    input  logic             req1_valid,
    output logic             req0_ready,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_s,
    output logic             rsp_c,
`ifdef ADDER_ARB_STATS_EN
    output logic [15:0]      cnt0,
    output logic [15:0]      cnt1,
`endif
    output logic             rsp_id
);
    logic             last_grant_r;
    logic             grant_s;
    logic             slot_free_s;
    logic             xfer_s;
    logic [WIDTH-1:0] op_a_s;
    logic [WIDTH-1:0] op_b_s;
    logic [WIDTH-1:0] sum_s;
    logic             carry_s;

    // Round-robin grant: on a tie the requester that did not win last goes next
    always_comb begin
        grant_s = 1'b0;
        if (req0_valid && req1_valid) begin
            grant_s = ~last_grant_r;
        end else if (req1_valid) begin
            grant_s = 1'b1;
        end else begin
            grant_s = 1'b0;
        end
    end

    // Operand mux feeding the single shared adder
    always_comb begin
        op_a_s = req0_a;
        op_b_s = req0_b;
        if (grant_s) begin
            op_a_s = req1_a;
            op_b_s = req1_b;
        end else begin
            op_a_s = req0_a;
            op_b_s = req0_b;
        end
    end

    adder_rca #(.WIDTH(WIDTH)) u_adder (
        .a (op_a_s),
        .b (op_b_s),
        .s (sum_s),
        .c (carry_s)
    );

    // Ready is gated by rst_n so neither requester is accepted while reset is held
    assign slot_free_s = ~rsp_valid | rsp_ready;
    assign req0_ready  = rst_n & ~grant_s & req0_valid & slot_free_s;
    assign req1_ready  = rst_n &  grant_s & req1_valid & slot_free_s;
    assign xfer_s      = req0_ready | req1_ready;

    // Result stage: load on transfer, drop on delivery, otherwise hold
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid    <= 1'b0;
            rsp_s        <= {WIDTH{1'b0}};
            rsp_c        <= 1'b0;
            rsp_id       <= 1'b0;
            last_grant_r <= 1'b1;
        end else if (xfer_s) begin
            rsp_valid    <= 1'b1;
            rsp_s        <= sum_s;
            rsp_c        <= carry_s;
            rsp_id       <= grant_s;
            last_grant_r <= grant_s;
        end else if (rsp_valid && rsp_ready) begin
            rsp_valid    <= 1'b0;
        end else begin
            rsp_valid    <= rsp_valid;
        end
    end

`ifdef ADDER_ARB_STATS_EN
    // Saturating per-requester transfer counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt0 <= 16'h0000;
            cnt1 <= 16'h0000;
        end else begin
            if (req0_ready && (cnt0 != 16'hFFFF)) begin
                cnt0 <= cnt0 + 16'h0001;
            end
            if (req1_ready && (cnt1 != 16'hFFFF)) begin
                cnt1 <= cnt1 + 16'h0001;
            end
        end
    end
`endif
endmodule

// File: tb/tb_adder_arbiter.sv
// Directed self-checking bench for adder_arbiter at WIDTH=8.
// The counter scenario runs only when ADDER_ARB_STATS_EN is defined.

module tb_adder_arbiter;
    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         req0_valid, req1_valid;
    logic         req0_ready, req1_ready;
    logic [W-1:0] req0_a, req0_b, req1_a, req1_b;
    logic         rsp_valid, rsp_ready;
    logic [W-1:0] rsp_s;
    logic         rsp_c, rsp_id;
`ifdef ADDER_ARB_STATS_EN
    logic [15:0]  cnt0, cnt1;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    adder_arbiter #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req0_valid (req0_valid),
        .req1_valid (req1_valid),
        .req0_ready (req0_ready),
        .req1_ready (req1_ready),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_s      (rsp_s),
        .rsp_c      (rsp_c),
`ifdef ADDER_ARB_STATS_EN
        .cnt0       (cnt0),
        .cnt1       (cnt1),
`endif
        .rsp_id     (rsp_id)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; rsp_ready = 1'b0;
        req0_valid = 1'b1; req1_valid = 1'b1;
        req0_a = 8'd0; req0_b = 8'd0; req1_a = 8'd0; req1_b = 8'd0;

        // reset state, including no ready while requests are pending
        step(); step();
        check_val("rst_valid", rsp_valid, 1'b0);
        check_val("rst_s", rsp_s, 8'h00);
        check_val("rst_c", rsp_c, 1'b0);
        check_val("rst_id", rsp_id, 1'b0);
        check_val("rst_rdy0", req0_ready, 1'b0);
        check_val("rst_rdy1", req1_ready, 1'b0);
        req0_valid = 1'b0; req1_valid = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        step();

        // single request 3 + 4
        req0_valid = 1'b1; req0_a = 8'd3; req0_b = 8'd4; rsp_ready = 1'b1;
        #1;
        check_val("single_rdy0", req0_ready, 1'b1);
        check_val("single_rdy1", req1_ready, 1'b0);
        step();
        check_val("single_valid", rsp_valid, 1'b1);
        check_val("single_s", rsp_s, 8'd7);
        check_val("single_c", rsp_c, 1'b0);
        check_val("single_id", rsp_id, 1'b0);

        // fresh reset so the tie sequence starts at requester 0
        req0_valid = 1'b0;
        rst_n = 1'b0; #2;
        @(negedge clk); rst_n = 1'b1;
        step();

        // both valid: alternate 0,1,0,1
        req0_valid = 1'b1; req0_a = 8'd10;  req0_b = 8'd20;
        req1_valid = 1'b1; req1_a = 8'd100; req1_b = 8'd50;
        rsp_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            check_val("rr_rdy0", req0_ready, (i % 2) == 0);
            check_val("rr_rdy1", req1_ready, (i % 2) == 1);
            step();
            check_val("rr_id", rsp_id, i % 2);
            check_val("rr_s", rsp_s, ((i % 2) == 0) ? 8'd30 : 8'd150);
            check_val("rr_valid", rsp_valid, 1'b1);
        end

        // backpressure: result 150 from req1 held while req1 waits
        req0_valid = 1'b0; req1_a = 8'h10; req1_b = 8'h20; rsp_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            check_val("bp_rdy1", req1_ready, 1'b0);
            step();
            check_val("bp_valid", rsp_valid, 1'b1);
            check_val("bp_s", rsp_s, 8'd150);
            check_val("bp_id", rsp_id, 1'b1);
        end
        rsp_ready = 1'b1;
        #1;
        check_val("bp_release_rdy1", req1_ready, 1'b1);
        step();
        check_val("bp_new_s", rsp_s, 8'h30);
        check_val("bp_new_id", rsp_id, 1'b1);
        check_val("bp_new_valid", rsp_valid, 1'b1);
        req1_valid = 1'b0;
        step();
        check_val("drain_valid", rsp_valid, 1'b0);

        // carry boundaries
        req0_valid = 1'b1; req0_a = 8'hFF; req0_b = 8'h01;
        step();
        check_val("ff01_s", rsp_s, 8'h00);
        check_val("ff01_c", rsp_c, 1'b1);
        check_val("ff01_id", rsp_id, 1'b0);
        req0_a = 8'h80; req0_b = 8'h80;
        step();
        check_val("8080_s", rsp_s, 8'h00);
        check_val("8080_c", rsp_c, 1'b1);

        // hold a result, then asynchronous reset drops it; last winner was req0
        req0_a = 8'h05; req0_b = 8'h06; rsp_ready = 1'b0;
        step();
        req0_valid = 1'b0;
        step();
        check_val("pre_rst_valid", rsp_valid, 1'b1);
        #2; rst_n = 1'b0; #1;
        check_val("async_rst_valid", rsp_valid, 1'b0);
        check_val("async_rst_c", rsp_c, 1'b0);
        @(negedge clk); rst_n = 1'b1;
        req0_valid = 1'b1; req0_a = 8'd1; req0_b = 8'd2;
        req1_valid = 1'b1; req1_a = 8'd9; req1_b = 8'd9;
        rsp_ready = 1'b1;
        #1;
        check_val("post_rst_rdy0", req0_ready, 1'b1);
        check_val("post_rst_rdy1", req1_ready, 1'b0);
        step();
        check_val("post_rst_id", rsp_id, 1'b0);
        check_val("post_rst_s", rsp_s, 8'd3);

`ifdef ADDER_ARB_STATS_EN
        // counter saturation
        req1_valid = 1'b0;
        rst_n = 1'b0; #2;
        @(negedge clk); rst_n = 1'b1;
        check_val("cnt0_rst", cnt0, 16'h0000);
        for (int i = 0; i < 70000; i++) step();
        check_val("cnt0_sat", cnt0, 16'hFFFF);
        check_val("cnt1_zero", cnt1, 16'h0000);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
